mips_exec_unit: RTL and testbench
=================================

# mips_exec_unit

Execute/control stage paired with the unified main memory. It consumes the instruction and load data the memory returns, and produces the next PC, data address, store data and store strobe the memory samples. It keeps the program counter and a 32×32 register file, and implements a MIPS-subset datapath. It alternates with the memory's execute/fetch phase (E).

## Interface
- No parameters. Widths are fixed at 32-bit data, 32 registers and byte addresses.
- clk  in  1  single clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- E  in  1  memory phase: 1 = execute, 0 = fetch.
- Iout  in  32  current instruction from memory; valid while E=1.
- Mout  in  32  memory data; while E=0 it holds the word read in the preceding E=1 cycle.
- Next_PC  out  32  byte address of the next instruction; always equals pc_reg.
- data_addr_in  out  32  data byte address, rs + sign_extend(imm16).
- data_in  out  32  store data, rf[rt].
- S  out  1  store strobe.
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct.
- retired  out  32  count of executed instructions, wrapping modulo 2^32.

## Operation
- Decode fields from Iout: op [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm [15:0], target [25:0].
- Supported instructions:
  - R-type (op 0x00) funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed).
  - addi 0x08, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02.
- Arithmetic wraps modulo 2^32. There are no overflow traps.
- The addi and memory offsets are sign-extended.
- r0 always reads 0. Writes to r0 are discarded.
- Execute cycle (E=1), combinational outputs:
  - data_addr_in and data_in are driven for every instruction.
  - S = 1 only for sw.
- Execute cycle, at the closing edge:
  - R-type writes rd; addi writes rt.
  - pc_reg advances:
    - default: pc_reg + 4.
    - beq/bne taken: pc_reg + 4 + (sext(imm) << 2).
    - j: {(pc_reg+4)[31:28], target, 2'b00}.
  - lw sets load_pending and latches rt into load_rd.
  - retired increments.
  - Unsupported encodings act as NOP (PC+4, no writes). illegal goes high for the cycle after the edge.
- Fetch cycle (E=0):
  - S = 0. No register or PC updates occur.
  - If load_pending, the closing edge writes Mout to rf[load_rd] and clears load_pending.
- States: EXEC (E=1) and FETCH_WB (E=0), selected directly by E. The block holds no independent phase counter.
- If E=1 arrives while load_pending is still set (phase slip), the pending load is dropped, no write occurs, and the new instruction executes normally.

## Timing
- Reset values:
  - pc_reg / Next_PC = 0.
  - All of rf = 0.
  - load_pending = 0, S = 0, illegal = 0, retired = 0.
  - data_addr_in and data_in follow the cleared rf: 0 + sext(imm).
- Reset takes priority over every update, including a pending load write-back. A load in flight is discarded.
- Instruction latency is 2 cycles (execute plus fetch). A load's result is visible to the next instruction with no hazard stall.
- Next_PC changes only at the closing edge of an execute cycle and is stable throughout the fetch cycle.
- S is combinational from Iout and E and is asserted only during E=1. The memory writes at that edge.
- If a single instruction both writes a register and reads it, the read uses the old value: reads are combinational and writes occur at the edge.

## Test plan
- Reset: hold Reset=1 for 2 cycles with arbitrary E and Iout. Required: Next_PC=0, S=0, retired=0, illegal=0; afterwards rf reads return 0.
- ALU: load r1=5 and r2=7 via addi.
  - add r3,r1,r2 → r3=12.
  - sub r4,r1,r2 → r4=0xFFFFFFFE.
  - slt r5,r4,r1 → r5=1.
  - Next_PC steps by 4 on each execute cycle.
- Store: with r4=0x100 and r5=0xDEADBEEF, Iout=0xAC850022 (sw r5,0x22(r4)) with E=1. Required: S=1, data_addr_in=0x122, data_in=0xDEADBEEF. In the next E=0 cycle, S=0.
- Load: lw r6,0(r0), then Mout=0x12345678 during E=0. Required: r6=0x12345678 after that edge. The next instruction, add r7,r6,r0, gives r7=0x12345678.
- Branch/jump, each starting from pc=0x40:
  - beq r0,r0,-2 → Next_PC=0x3C.
  - bne r0,r0,+3 → Next_PC=0x44.
  - j 0x100 → Next_PC=0x400.
  - An illegal op 0x3F gives an illegal pulse, Next_PC=0x44, and no register change.
- Reset mid-load: execute lw r8, then assert Reset during the fetch cycle. Required: r8 stays 0, load_pending clears, and Next_PC=0.

Source files
------------

// File: rtl/mips_exec_unit.sv
// mips_exec_unit: MIPS-subset execute/write-back stage that alternates with memory's execute/fetch phase.
// Holds the PC, a 32x32 register file and the retired-instruction counter.
module mips_exec_unit (
    input  logic        clk,
    input  logic        Reset,
    input  logic        E,
    input  logic [31:0] Iout,
    input  logic [31:0] Mout,
    output logic [31:0] Next_PC,
    output logic [31:0] data_addr_in,
    output logic [31:0] data_in,
    output logic        S,
    output logic        illegal,
    output logic [31:0] retired
);
    typedef enum logic {FETCH_WB, EXEC} phase_t;
    phase_t      state;
    logic [31:0] rf [32];
    logic [31:0] pc_reg, rs_val, rt_val, sext_imm, pc4, npc, alu, wr_data;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, wr_addr, load_rd;
    logic [25:0] target;
    logic        load_pending, is_r, r_ok, legal, taken, wr_en;

    always_comb begin
        state    = E ? EXEC : FETCH_WB;
        op       = Iout[31:26];
        rs       = Iout[25:21];
        rt       = Iout[20:16];
        rd       = Iout[15:11];
        funct    = Iout[5:0];
        target   = Iout[25:0];
        sext_imm = {{16{Iout[15]}}, Iout[15:0]};
        rs_val   = rf[rs];
        rt_val   = rf[rt];
        is_r     = op == 6'h00;
        alu      = funct == 6'h20 ? rs_val + rt_val :
                   funct == 6'h22 ? rs_val - rt_val :
                   funct == 6'h24 ? rs_val & rt_val :
                   funct == 6'h25 ? rs_val | rt_val :
                   {31'd0, $signed(rs_val) < $signed(rt_val)};
        r_ok     = is_r && (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
                            funct == 6'h25 || funct == 6'h2A);
        legal    = r_ok || op == 6'h08 || op == 6'h23 || op == 6'h2B ||
                   op == 6'h04 || op == 6'h05 || op == 6'h02;
        taken    = (op == 6'h04 && rs_val == rt_val) || (op == 6'h05 && rs_val != rt_val);
        pc4      = pc_reg + 32'd4;
        npc      = op == 6'h02 ? {pc4[31:28], target, 2'b00} :
                   taken ? pc4 + {sext_imm[29:0], 2'b00} : pc4;
        wr_en    = state == EXEC && (r_ok || op == 6'h08);
        wr_addr  = is_r ? rd : rt;
        wr_data  = is_r ? alu : rs_val + sext_imm;
    end

    assign Next_PC      = pc_reg;
    assign data_addr_in = rs_val + sext_imm;
    assign data_in      = rt_val;
    // Gated by Reset so memory never stores while the unit is being cleared
    assign S            = state == EXEC && !Reset && op == 6'h2B;

    always_ff @(posedge clk) begin
        if (Reset) begin
            pc_reg       <= '0;
            load_pending <= 1'b0;
            load_rd      <= '0;
            illegal      <= 1'b0;
            retired      <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            illegal <= state == EXEC && !legal;
            if (state == EXEC) begin
                pc_reg       <= npc;
                retired      <= retired + 32'd1;
                // A new execute drops any load still waiting for its fetch cycle
                load_pending <= op == 6'h23;
                load_rd      <= rt;
                if (wr_en && wr_addr != 5'd0) rf[wr_addr] <= wr_data;
            end else if (load_pending) begin
                if (load_rd != 5'd0) rf[load_rd] <= Mout;
                load_pending <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mips_exec_unit.sv
// tb_mips_exec_unit: directed and randomized checks of mips_exec_unit against an instruction-level model.
module tb_mips_exec_unit;
    logic        clk = 0, Reset, E;
    logic [31:0] Iout, Mout, Next_PC, data_addr_in, data_in, retired;
    logic        S, illegal;
    int          tests = 0, fails = 0;

    logic [31:0] m_rf [32];
    logic [31:0] m_pc, m_ret;
    logic        m_pend, m_ill;
    int          m_ld;

    mips_exec_unit dut (
        .clk(clk), .Reset(Reset), .E(E), .Iout(Iout), .Mout(Mout),
        .Next_PC(Next_PC), .data_addr_in(data_addr_in), .data_in(data_in),
        .S(S), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(int rs, int rt, int rd, int f);
        return (rs << 21) | (rt << 16) | (rd << 11) | f;
    endfunction
    function automatic logic [31:0] itype(int op, int rs, int rt, logic [15:0] imm);
        return (op << 26) | (rs << 21) | (rt << 16) | imm;
    endfunction
    function automatic logic [31:0] sx(logic [31:0] i);
        return {{16{i[15]}}, i[15:0]};
    endfunction
    function automatic bit ok(logic [31:0] i);
        int op = int'(i[31:26]), f = int'(i[5:0]);
        if (op == 0) return f == 'h20 || f == 'h22 || f == 'h24 || f == 'h25 || f == 'h2A;
        return op == 'h08 || op == 'h23 || op == 'h2B || op == 'h04 || op == 'h05 || op == 'h02;
    endfunction

    // Instruction-level reference: one call per clock edge with the inputs held during that cycle
    task automatic model(input logic rst, input logic e, input logic [31:0] i, input logic [31:0] m);
        logic [31:0] a, b;
        int op, rs, rt, rd, f;
        if (rst) begin
            foreach (m_rf[k]) m_rf[k] = 0;
            m_pc = 0; m_ret = 0; m_pend = 0; m_ill = 0; m_ld = 0;
            return;
        end
        m_ill = e && !ok(i);
        if (!e) begin
            if (m_pend) m_rf[m_ld] = m;
            m_pend = 0;
        end else begin
            op = int'(i[31:26]); rs = int'(i[25:21]); rt = int'(i[20:16]); rd = int'(i[15:11]); f = int'(i[5:0]);
            a = m_rf[rs]; b = m_rf[rt];
            m_pend = op == 'h23; m_ld = rt;
            m_ret = m_ret + 1;
            if (op == 0 && ok(i))
                m_rf[rd] = f == 'h20 ? a + b : f == 'h22 ? a - b : f == 'h24 ? a & b :
                           f == 'h25 ? a | b : ($signed(a) < $signed(b) ? 32'd1 : 32'd0);
            else if (op == 'h08) m_rf[rt] = a + sx(i);
            if (op == 'h02) m_pc = {m_pc[31:28] + ((m_pc[27:0] + 28'd4) == 28'd0 ? 4'd1 : 4'd0), i[25:0], 2'b00};
            else if ((op == 'h04 && a == b) || (op == 'h05 && a != b)) m_pc = m_pc + 4 + sx(i) * 4;
            else m_pc = m_pc + 4;
        end
        m_rf[0] = 0;
    endtask

    task automatic drive(input logic rst, input logic e, input logic [31:0] i, input logic [31:0] m);
        Reset = rst; E = e; Iout = i; Mout = m;
        #3;
    endtask

    task automatic edge_step();
        model(Reset, E, Iout, Mout);
        @(posedge clk); #1;
    endtask

    task automatic exec_fetch(input logic [31:0] i, input logic [31:0] m);
        drive(0, 1, i, 0); edge_step();
        drive(0, 0, 0, m); edge_step();
    endtask

    task automatic check_state(input string name);
        tests++;
        if (Next_PC !== m_pc || retired !== m_ret || illegal !== m_ill) begin
            fails++;
            $display("FAIL %s: pc=%h ret=%0d ill=%b, expected pc=%h ret=%0d ill=%b",
                     name, Next_PC, retired, illegal, m_pc, m_ret, m_ill);
        end
    endtask

    task automatic check_rf(input string name);
        for (int r = 0; r < 32; r++) begin
            drive(0, 0, rtype(r, r, 0, 0), 0);
            tests++;
            if (data_addr_in !== m_rf[r] || data_in !== m_rf[r]) begin
                fails++;
                $display("FAIL %s r%0d: got %h/%h expected %h", name, r, data_addr_in, data_in, m_rf[r]);
            end
            edge_step();
        end
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0); edge_step();
        drive(1, 0, 0, 0); edge_step();
    endtask

    task automatic test_reset();
        drive(1, 1, itype('h2B, 3, 4, 16'h10), $urandom);
        tests++;
        if (S !== 1'b0) begin fails++; $display("FAIL reset_S: got %b expected 0", S); end
        edge_step();
        drive(1, 1, 32'hFC000000, $urandom); edge_step();
        tests++;
        if (Next_PC !== 0 || retired !== 0 || illegal !== 0) begin
            fails++;
            $display("FAIL reset_vals: pc=%h ret=%0d ill=%b expected 0", Next_PC, retired, illegal);
        end
        check_rf("reset_rf");
    endtask

    task automatic test_alu();
        logic [31:0] want [5] = '{5, 7, 12, 32'hFFFFFFFE, 1};
        logic [31:0] ins [5];
        ins[0] = itype('h08, 0, 1, 5);
        ins[1] = itype('h08, 0, 2, 7);
        ins[2] = rtype(1, 2, 3, 'h20);
        ins[3] = rtype(1, 2, 4, 'h22);
        ins[4] = rtype(4, 1, 5, 'h2A);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, ins[k], 0); edge_step();
            tests++;
            if (Next_PC !== 32'(4 * (k + 1))) begin
                fails++; $display("FAIL alu_pc%0d: got %h expected %h", k, Next_PC, 4 * (k + 1));
            end
            drive(0, 0, rtype(k + 1, 0, 0, 0), 0);
            tests++;
            if (data_addr_in !== want[k]) begin
                fails++; $display("FAIL alu_r%0d: got %h expected %h", k + 1, data_addr_in, want[k]);
            end
            edge_step();
        end
        check_state("alu_state");
    endtask

    task automatic test_store();
        do_reset();
        exec_fetch(itype('h08, 0, 4, 16'h0100), 0);
        exec_fetch(itype('h23, 0, 5, 0), 32'hDEADBEEF);
        drive(0, 1, 32'hAC850022, 0);
        tests++;
        if (S !== 1 || data_addr_in !== 32'h122 || data_in !== 32'hDEADBEEF) begin
            fails++; $display("FAIL store: S=%b addr=%h data=%h expected 1/122/deadbeef", S, data_addr_in, data_in);
        end
        edge_step();
        drive(0, 0, 32'hAC850022, 0);
        tests++;
        if (S !== 0) begin fails++; $display("FAIL store_fetch_S: got %b expected 0", S); end
        edge_step();
    endtask

    task automatic test_load();
        exec_fetch(itype('h23, 0, 6, 0), 32'h12345678);
        drive(0, 0, rtype(6, 0, 0, 0), 0);
        tests++;
        if (data_addr_in !== 32'h12345678) begin
            fails++; $display("FAIL load_r6: got %h expected 12345678", data_addr_in);
        end
        edge_step();
        exec_fetch(rtype(6, 0, 7, 'h20), 32'h0BAD0BAD);
        drive(0, 0, rtype(7, 0, 0, 0), 0);
        tests++;
        if (data_addr_in !== 32'h12345678) begin
            fails++; $display("FAIL load_use_r7: got %h expected 12345678", data_addr_in);
        end
        edge_step();
    endtask

    task automatic test_branch();
        logic [31:0] ins [4] = '{32'h1000FFFE, 32'h14000003, 32'h08000100, 32'hFC000000};
        logic [31:0] want [4] = '{32'h3C, 32'h44, 32'h400, 32'h44};
        for (int k = 0; k < 4; k++) begin
            exec_fetch(32'h08000010, 0);
            tests++;
            if (Next_PC !== 32'h40) begin fails++; $display("FAIL br_setup%0d: got %h expected 40", k, Next_PC); end
            drive(0, 1, ins[k], 0); edge_step();
            tests++;
            if (Next_PC !== want[k] || illegal !== (k == 3)) begin
                fails++; $display("FAIL branch%0d: pc=%h ill=%b expected %h/%b", k, Next_PC, illegal, want[k], k == 3);
            end
            drive(0, 0, 0, 0); edge_step();
            tests++;
            if (illegal !== 0) begin fails++; $display("FAIL illegal_pulse%0d: got %b expected 0", k, illegal); end
        end
        check_state("branch_state");
        check_rf("branch_rf");
    endtask

    task automatic test_random();
        logic e, prev_e = 0;
        logic [31:0] i;
        int kinds [10] = '{0, 0, 'h08, 'h23, 'h2B, 'h04, 'h05, 'h02, 'h3F, 0};
        int funcs [6] = '{'h20, 'h22, 'h24, 'h25, 'h2A, 'h21};
        do_reset();
        for (int c = 0; c < 400; c++) begin
            e = ($urandom_range(0, 7) == 0) ? prev_e : !prev_e;
            i = {$urandom} & 32'h03FFFFFF;
            i[31:26] = 6'(kinds[$urandom_range(0, 9)]);
            if (i[31:26] == 0) i[5:0] = 6'(funcs[$urandom_range(0, 5)]);
            drive(0, e, i, $urandom);
            tests++;
            if (data_addr_in !== m_rf[i[25:21]] + sx(i) || data_in !== m_rf[i[20:16]] ||
                S !== (e && i[31:26] == 6'h2B)) begin
                fails++;
                $display("FAIL rand_comb%0d: addr=%h data=%h S=%b", c, data_addr_in, data_in, S);
            end
            edge_step();
            check_state("rand_state");
            prev_e = e;
        end
        drive(0, 0, 0, $urandom); edge_step();
        check_rf("rand_rf");
    endtask

    task automatic test_reset_midload();
        do_reset();
        drive(0, 1, itype('h23, 0, 8, 0), 0); edge_step();
        drive(1, 0, 0, 32'hCAFEF00D); edge_step();
        drive(0, 0, 0, 32'h55AA55AA); edge_step();
        drive(0, 0, rtype(8, 8, 0, 0), 0);
        tests++;
        if (data_addr_in !== 0 || Next_PC !== 0 || retired !== 0) begin
            fails++; $display("FAIL reset_midload: r8=%h pc=%h ret=%0d expected 0/0/0", data_addr_in, Next_PC, retired);
        end
        edge_step();
        check_rf("midload_rf");
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_alu();
        test_store();
        test_load();
        test_branch();
        test_random();
        test_reset_midload();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
